// File: rtl/adder_rr_sched.sv
// Round-robin arbiter sharing one WIDTH-bit adder among NREQ requesters.
// Results are queued with the winning requester ID in a 2-entry FIFO.
module adder_rr_sched #(
  parameter  int WIDTH = 4,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NREQ-1:0]         i_req_vld,
  input  logic [NREQ*WIDTH-1:0]   i_a,
  input  logic [NREQ*WIDTH-1:0]   i_b,
  output logic [NREQ-1:0]         o_req_rdy,
  output logic                    o_rsp_vld,
  output logic [IDW-1:0]          o_rsp_id,
  output logic [WIDTH:0]          o_sum,
  input  logic                    i_rsp_rdy,
  output logic                    o_busy
);

  // Returns {found, index} of the first valid requester at or after ptr.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] vld,
                                           input logic [IDW-1:0]  ptr);
    logic [IDW:0] res;
    int           k;
    res = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % NREQ;
      if (vld[k]) begin
        res = {1'b1, IDW'(k)};
      end
    end
    return res;
  endfunction

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;
  logic [IDW-1:0]  id_q  [2];
  logic [WIDTH:0]  sum_q [2];

  logic [IDW:0]    pick_s;
  logic [IDW-1:0]  gnt_idx_s;
  logic [NREQ-1:0] gnt_s;
  logic            acc_s;
  logic            pop_s;
  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_s;
  logic [WIDTH:0]  sum_s;

  // Grant depends only on registered occupancy, never on i_rsp_rdy.
  always_comb begin
    pick_s    = rr_pick(i_req_vld, ptr_q);
    gnt_idx_s = pick_s[IDW-1:0];
    acc_s     = (cnt_q < 2'd2) & pick_s[IDW];
    gnt_s     = '0;
    if (acc_s) begin
      gnt_s[gnt_idx_s] = 1'b1;
    end else begin
      gnt_s = '0;
    end
    a_s   = i_a[gnt_idx_s*WIDTH +: WIDTH];
    b_s   = i_b[gnt_idx_s*WIDTH +: WIDTH];
    sum_s = {1'b0, a_s} + {1'b0, b_s};
  end

  always_comb begin
    pop_s = (cnt_q != 2'd0) & i_rsp_rdy;
    case ({acc_s, pop_s})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    wr_d = acc_s ? ~wr_q : wr_q;
    rd_d = pop_s ? ~rd_q : rd_q;
    if (acc_s) begin
      ptr_d = (gnt_idx_s == IDW'(NREQ - 1)) ? '0 : gnt_idx_s + IDW'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
      cnt_q <= 2'd0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      for (int e = 0; e < 2; e++) begin
        id_q[e]  <= '0;
        sum_q[e] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      if (acc_s) begin
        id_q[wr_q]  <= gnt_idx_s;
        sum_q[wr_q] <= sum_s;
      end
    end
  end

  always_comb begin
    o_req_rdy = gnt_s;
    o_rsp_vld = (cnt_q != 2'd0);
    o_rsp_id  = id_q[rd_q];
    o_sum     = sum_q[rd_q];
    o_busy    = (cnt_q != 2'd0) | (|i_req_vld);
  end

endmodule

// File: tb/tb_adder_rr_sched.sv
// Self-checking bench for adder_rr_sched: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_adder_rr_sched;
  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int AW    = NREQ * WIDTH;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] vld;
  logic [AW-1:0]   a, b;
  logic            rr;
  logic [NREQ-1:0] o_req_rdy;
  logic            o_rsp_vld;
  logic [IDW-1:0]  o_rsp_id;
  logic [WIDTH:0]  o_sum;
  logic            o_busy;

  always #5 clk = ~clk;

  adder_rr_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_vld(vld), .i_a(a), .i_b(b),
    .o_req_rdy(o_req_rdy), .o_rsp_vld(o_rsp_vld), .o_rsp_id(o_rsp_id),
    .o_sum(o_sum), .i_rsp_rdy(rr), .o_busy(o_busy)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct { int id; int sum; } ent_t;
  ent_t mq[$];
  int   mptr    = 0;
  int   exp_gnt = -1;

  function automatic int model_grant();
    int k;
    if (mq.size() >= 2) return -1;
    for (int i = 0; i < NREQ; i++) begin
      k = (mptr + i) % NREQ;
      if (vld[k]) return k;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic [NREQ-1:0] v,
                       input logic [AW-1:0] av, input logic [AW-1:0] bv, input logic r);
    @(negedge clk);
    rst_n = rst; vld = v; a = av; b = bv; rr = r;
    if (!rst) begin
      mq.delete();
      mptr = 0;
    end
    #1;
    exp_gnt = model_grant();
    chk("req_rdy", 32'(o_req_rdy), (exp_gnt < 0) ? 32'd0 : (32'd1 << exp_gnt));
    chk("rsp_vld", 32'(o_rsp_vld), (mq.size() != 0) ? 32'd1 : 32'd0);
    if (mq.size() != 0) begin
      chk("rsp_id", 32'(o_rsp_id), 32'(mq[0].id));
      chk("sum",    32'(o_sum),    32'(mq[0].sum));
    end
    chk("busy", 32'(o_busy), ((mq.size() != 0) || (v != '0)) ? 32'd1 : 32'd0);
  endtask

  task automatic tick();
    ent_t e;
    @(posedge clk);
    if (rst_n) begin
      if (mq.size() != 0 && rr) void'(mq.pop_front());
      if (exp_gnt >= 0) begin
        e.id  = exp_gnt;
        e.sum = int'(a[exp_gnt*WIDTH +: WIDTH]) + int'(b[exp_gnt*WIDTH +: WIDTH]);
        mq.push_back(e);
        mptr = (exp_gnt + 1) % NREQ;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; vld = '0; a = '0; b = '0; rr = 1'b0;
    drive(1'b0, 4'b0000, '0, '0, 1'b0);
    chk("rst_vld", 32'(o_rsp_vld), 32'd0);
    chk("rst_sum", 32'(o_sum), 32'd0);
    tick();

    // Single request: 9 + 8 = 17 from requester 2
    drive(1'b1, 4'b0100, 16'h0900, 16'h0800, 1'b1);
    chk("t2_rdy", 32'(o_req_rdy), 32'h4);
    tick();
    drive(1'b1, 4'b0000, '0, '0, 1'b1);
    chk("t2_vld", 32'(o_rsp_vld), 32'd1);
    chk("t2_id",  32'(o_rsp_id),  32'd2);
    chk("t2_sum", 32'(o_sum),     32'd17);
    tick();

    // Rotation from ptr=0 with all requesters valid
    drive(1'b0, 4'b0000, '0, '0, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'b1111, 16'h4321, 16'h1111, 1'b1);
      chk("t3_rdy", 32'(o_req_rdy), 32'd1 << (i % 4));
      if (i > 0) chk("t3_id", 32'(o_rsp_id), 32'((i - 1) % 4));
      tick();
    end

    // Skip and wrap from ptr=1 with a push/pop at cnt=1
    drive(1'b1, 4'b1001, 16'h7000, 16'h1000, 1'b1);
    chk("t6_rdy1", 32'(o_req_rdy), 32'h8);
    chk("t6_head0", 32'(o_rsp_id), 32'd0);
    tick();
    drive(1'b1, 4'b1001, 16'h0003, 16'h0004, 1'b1);
    chk("t6_rdy2", 32'(o_req_rdy), 32'h1);
    chk("t6_id3", 32'(o_rsp_id), 32'd3);
    chk("t6_sum3", 32'(o_sum), 32'd8);
    tick();
    drive(1'b1, 4'b0000, '0, '0, 1'b1);
    chk("t6_id0", 32'(o_rsp_id), 32'd0);
    chk("t6_sum0", 32'(o_sum), 32'd7);
    tick();

    // Backpressure after reset
    drive(1'b0, 4'b0000, '0, '0, 1'b0);
    tick();
    drive(1'b1, 4'b1111, 16'h2222, 16'h1111, 1'b0);
    chk("t4_g0", 32'(o_req_rdy), 32'h1);
    tick();
    drive(1'b1, 4'b1111, 16'h2222, 16'h1111, 1'b0);
    chk("t4_g1", 32'(o_req_rdy), 32'h2);
    tick();
    drive(1'b1, 4'b1111, 16'h2222, 16'h1111, 1'b0);
    chk("t4_stall", 32'(o_req_rdy), 32'h0);
    chk("t4_hold", 32'(o_rsp_id), 32'd0);
    tick();
    drive(1'b1, 4'b1111, 16'h2222, 16'h1111, 1'b1);
    chk("t4_nogrant", 32'(o_req_rdy), 32'h0);
    tick();
    drive(1'b1, 4'b1111, 16'h2222, 16'h1111, 1'b0);
    chk("t4_g2", 32'(o_req_rdy), 32'h4);
    chk("t4_head1", 32'(o_rsp_id), 32'd1);
    tick();

    // Reset with a full FIFO
    drive(1'b0, 4'b1111, 16'h2222, 16'h1111, 1'b0);
    chk("t1_vld", 32'(o_rsp_vld), 32'd0);
    chk("t1_sum", 32'(o_sum), 32'd0);
    chk("t1_id", 32'(o_rsp_id), 32'd0);
    tick();
    drive(1'b1, 4'b1111, 16'h2222, 16'h1111, 1'b1);
    chk("t1_first", 32'(o_req_rdy), 32'h1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'b0000, '0, '0, 1'b1);
      tick();
    end

    // Width extremes on requester 0
    begin
      logic [AW-1:0] xa [3];
      logic [AW-1:0] xb [3];
      int            xs [3];
      xa[0] = 16'h000F; xb[0] = 16'h000F; xs[0] = 30;
      xa[1] = 16'h000F; xb[1] = 16'h0001; xs[1] = 16;
      xa[2] = 16'h0000; xb[2] = 16'h0000; xs[2] = 0;
      for (int i = 0; i < 3; i++) begin
        drive(1'b1, 4'b0001, xa[i], xb[i], 1'b1);
        tick();
        drive(1'b1, 4'b0000, '0, '0, 1'b1);
        chk("t5_sum", 32'(o_sum), 32'(xs[i]));
        tick();
      end
    end

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 299) != 0), NREQ'($urandom), AW'($urandom), AW'($urandom),
            ($urandom_range(0, 3) != 0));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_rr_sched.md
# adder_rr_sched

Round-robin scheduler that shares one WIDTH-bit adder among NREQ requesters. Each requester presents an operand pair under a valid/ready handshake. The block grants one requester per cycle, computes the (WIDTH+1)-bit sum, and queues it with the requester ID in a 2-entry result FIFO for a single downstream consumer. It sits between the requester-side logic and the shared adder datapath, and it is the only path to the adder.

## Interface
- WIDTH, 4: operand width; sum width is WIDTH+1.
- NREQ, 4: number of requesters, legal range 2..8. Derived IDW = $clog2(NREQ).

Ports:
- i_clk  in  1  single clock; all state on rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_req_vld  in  NREQ  bit r: requester r has an operand pair pending.
- i_a  in  NREQ*WIDTH  requester r operand A at [r*WIDTH +: WIDTH].
- i_b  in  NREQ*WIDTH  requester r operand B at [r*WIDTH +: WIDTH].
- o_req_rdy  out  NREQ  one-hot grant; requester r is accepted when i_req_vld[r] & o_req_rdy[r].
- o_rsp_vld  out  1  head FIFO entry valid.
- o_rsp_id  out  IDW  requester index of head entry.
- o_sum  out  WIDTH+1  sum of head entry.
- i_rsp_rdy  in  1  consumer ready; pop when o_rsp_vld & i_rsp_rdy.
- o_busy  out  1  asserted when FIFO is non-empty or any i_req_vld bit is set.

## Operation
- State:
  - rotating priority pointer ptr (IDW bits);
  - 2-entry FIFO of {id, sum} with cnt (0..2), rd/wr indices.
- Grant logic (combinational):
  - Enabled only when registered cnt < 2. There is no combinational path from i_rsp_rdy to o_req_rdy.
  - When enabled, search ptr, ptr+1, ..., ptr+NREQ-1 (mod NREQ) and grant the first index k with i_req_vld[k]=1.
  - Otherwise o_req_rdy = 0.
- Accept (grant k, i_req_vld[k]=1):
  - push {k, i_a[k] + i_b[k]}; both operands are zero-extended to WIDTH+1 bits, so the sum never overflows;
  - ptr <= (k+1) mod NREQ.
- No accept: ptr holds.
- Requester rules:
  - A requester may drop i_req_vld without a handshake; the grant is recomputed every cycle.
  - Operands need only be valid in the accept cycle.
- FIFO occupancy:
  - push only: cnt+1;
  - pop only: cnt-1;
  - push and pop together (only possible at cnt=1): cnt holds at 1, and the new entry becomes the head on the next cycle.
  - Push at cnt=2 cannot occur, because the grant is disabled at cnt=2.
- Outputs:
  - o_rsp_vld = (cnt != 0);
  - o_rsp_id and o_sum come from the head entry and are held stable while o_rsp_vld & !i_rsp_rdy.
- Reset (async, including mid-operation):
  - FIFO flushed: cnt=0, rd/wr=0, entries=0;
  - ptr=0;
  - o_rsp_vld=0, o_rsp_id=0, o_sum=0;
  - o_req_rdy follows the grant logic with ptr=0 and cnt=0;
  - any in-flight result is discarded.

## Timing
- Accept at edge t: result is visible on o_rsp_* from cycle t+1, i.e. 1-cycle latency when the FIFO was empty.
- Throughput is 1 accept/cycle sustained while the consumer holds i_rsp_rdy=1; cnt stays ≤ 1.
- Backpressure sequence:
  - with i_rsp_rdy=0, at most 2 accepts occur, after which o_req_rdy=0;
  - after the pop edge, cnt=1 and grants resume in that same following cycle.
- ptr wraps from NREQ-1 to 0.
- Fairness: a continuously valid requester is granted within NREQ grant-enabled cycles.

## Test plan
1. Reset mid-traffic: drop i_rst_n with cnt=2 → o_rsp_vld=0, o_sum=0, o_rsp_id=0 immediately. After release with i_req_vld=4'b1111, the first grant is 4'b0001.
2. Single request, WIDTH=4: i_req_vld=4'b0100, A2=9, B2=8, i_rsp_rdy=1 → o_req_rdy=4'b0100. Next cycle o_rsp_vld=1, o_rsp_id=2, o_sum=17.
3. Rotation: i_req_vld=4'b1111 held, i_rsp_rdy=1 → grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles; responses with ids 0, 1, 2, 3, 0 follow, each one cycle later.
4. Backpressure: i_req_vld=4'b1111, i_rsp_rdy=0 → ids 0 and 1 accepted, then o_req_rdy=0 with o_rsp_id=0 held. Raise i_rsp_rdy for one cycle → id 0 pops; the next cycle grants requester 2, and the head becomes id 1.
5. Width extremes: A=15, B=15 → o_sum=5'b11110 (30). A=15, B=1 → o_sum=16. A=0, B=0 → o_sum=0.
6. Skip and wrap: with ptr=1 and i_req_vld=4'b1001 → grant 4'b1000, ptr becomes 0, then grant 4'b0001 and ptr becomes 1. A simultaneous push/pop at cnt=1 leaves cnt=1 with no lost or duplicated entry.
